regbank_wr_sched: RTL and testbench
===================================

# regbank_wr_sched

Write scheduler for the shared 8-entry unpacked register bank. It arbitrates single-entry write requests from `N_REQ` requesters round-robin and commits one write per cycle into the bank. A fill sequencer walks every entry, one per cycle, to broadcast a value. It sits between the requesting modules and the bank, and drives the bank contents out as an unpacked array.

## Interface
Parameters:
- `N_REQ`, 4: number of write requesters, ≥2.
- `DEPTH`, 8: bank entries, power of two, ≥2.
- `WIDTH`, 1: bits per entry.

Ports:
- `i_clk`, in, 1: clock; all state on posedge.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_req [N_REQ]`, in, 1 each: write request, held until granted.
- `i_addr [N_REQ]`, in, `$clog2(DEPTH)` each: target entry per requester.
- `i_wdata [N_REQ]`, in, `WIDTH` each: write data per requester.
- `o_gnt [N_REQ]`, out, 1 each: one-hot (or all-zero) grant; write accepted this cycle.
- `i_fill`, in, 1: fill start pulse (only with fill feature).
- `i_fill_val`, in, `WIDTH`: fill value, sampled every fill cycle.
- `o_busy`, out, 1: fill sequence in progress.
- `o_q [DEPTH]`, out, `WIDTH` each: bank contents, unpacked, direct register outputs.

## Operation
- FSM states: `IDLE`, `FILL`. Reset state is `IDLE`.
- **IDLE, `i_fill`=0:**
  - `o_gnt` is combinational, one-hot over asserted `i_req`.
  - The winner is the first requester at or after the priority pointer `ptr`, scanning upward modulo `N_REQ`.
  - Granted requester k: `o_q[i_addr[k]] <= i_wdata[k]` at the next edge, and `ptr <= (k+1) mod N_REQ`.
  - No request: no write, `ptr` holds.
- **IDLE, `i_fill`=1:**
  - Fill beats requests; `o_gnt` is all-zero that cycle.
  - Next state is `FILL` with `cnt <= 0`.
- **FILL:**
  - Each cycle: `o_q[cnt] <= i_fill_val` and `cnt <= cnt+1`. `o_gnt` is all-zero and requests stall.
  - When `cnt == DEPTH-1`, the final entry is written and the next state is `IDLE`.
  - `i_fill` is ignored while in `FILL`.
- Requester protocol:
  - A requester may drop `i_req` or change `i_addr`/`i_wdata` only after the cycle its `o_gnt` is high.
  - Changing them while waiting is legal. The value present in the grant cycle is the one written.
- Entries not written hold their value. There is exactly one bank write per cycle, so there is never a write conflict.
- Reset values:
  - All `o_q` = 0, `o_gnt` = 0, `o_busy` = 0.
  - `ptr` = 0, `cnt` = 0, state `IDLE`.
- Reset mid-fill: abort, all entries zero, `IDLE` on the cycle after reset deasserts.

## Timing
- Grant latency: 0 cycles (grant in the first cycle the requester wins).
- Data visible on `o_q` 1 cycle after the grant edge.
- Worst-case wait for a continuously asserted request: `N_REQ-1` grants to others, plus any fill in progress (≤`DEPTH` cycles).
- `o_busy` is registered:
  - High for exactly `DEPTH` cycles, starting the cycle after the `i_fill` pulse.
  - Low in the cycle `IDLE` resumes; a grant is possible in that same cycle.
- Full fill: entry j takes `i_fill_val` sampled in fill cycle j. Entry `DEPTH-1` is updated at the edge ending `o_busy`.
- `cnt` wraps naturally at `DEPTH` (power of two); no separate terminal compare width is needed.

## Configuration
- Macro: `REGBANK_WR_SCHED_FILL_EN`.
- Defined:
  - `FILL` state, `cnt`, `i_fill`, `i_fill_val` and the `o_busy` logic are present as described.
- Undefined:
  - FSM reduces to `IDLE` only.
  - `i_fill` and `i_fill_val` remain ports but are ignored.
  - `o_busy` is tied 0.
  - Arbitration runs every cycle.

## Structure
- Package `regbank_pkg`:
  - State enum `regbank_state_e {IDLE, FILL}`.
  - Default constants `REGBANK_DEPTH = 8` and `REGBANK_NREQ = 4`.
- Sub-module `rr_arbiter`:
  - Parameter `N`; inputs `i_clk`, `i_rst`, `i_req[N]`, `i_en`; output `o_gnt[N]`.
  - Owns `ptr`; advances `ptr` only when `i_en` and a grant occur.
- Top level: FSM, fill counter, bank registers, write mux.

## Test plan
- Reset, then check all outputs → `o_q` all 0, `o_gnt` 0, `o_busy` 0.
- Requester 2 alone, addr 5, data 1 → `o_gnt[2]`=1 that cycle; `o_q[5]`=1 next cycle; others unchanged.
- All 4 requesters held continuously → grants 0,1,2,3,0 in consecutive cycles.
- After a grant to 1, requesters 0 and 3 assert → 3 granted first, then 0.
- `i_fill` with `i_fill_val`=1 while requester 0 asserts:
  - `o_busy` high for 8 cycles, entries 0..7 set in order, no grants.
  - `o_gnt[0]` in the cycle `o_busy` falls.
- `i_rst` at fill cycle 3 → all `o_q`=0, `o_busy`=0, and a request is granted on the first cycle after reset deasserts.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared types and default sizing for the register-bank write scheduler.
package regbank_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } regbank_state_e;

  localparam int unsigned REGBANK_DEPTH = 8;
  localparam int unsigned REGBANK_NREQ  = 4;

endpackage

// File: rtl/regbank_wr_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past each winner.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req [N],
  input  logic i_en,
  output logic o_gnt [N]
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic          w_found;
  int unsigned   w_idx;

  // First requester at or after the pointer, scanning upward modulo N.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      w_idx = 32'(r_ptr) + off;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && i_req[PW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = PW'(w_idx);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < int'(N); k++) begin
      o_gnt[k] = i_en && w_found && (w_win == PW'(k));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + PW'(1);
    end
  end

endmodule

// File: rtl/regbank_wr_sched.sv
// Write scheduler for the shared register bank: round-robin single writes plus an
// optional whole-bank fill sequence, enabled by REGBANK_WR_SCHED_FILL_EN.
module regbank_wr_sched
  import regbank_pkg::*;
#(
  parameter int unsigned N_REQ = REGBANK_NREQ,
  parameter int unsigned DEPTH = REGBANK_DEPTH,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req   [N_REQ],
  input  logic [AW-1:0]    i_addr  [N_REQ],
  input  logic [WIDTH-1:0] i_wdata [N_REQ],
  output logic             o_gnt   [N_REQ],
  input  logic             i_fill,
  input  logic [WIDTH-1:0] i_fill_val,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_q     [DEPTH]
);

  logic             w_arb_en;
  logic             w_fill_we;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_gnt [N_REQ];
  logic [WIDTH-1:0] r_q   [DEPTH];

  rr_arbiter #(.N(N_REQ)) u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req (i_req),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt)
  );

  assign o_gnt = w_gnt;

`ifdef REGBANK_WR_SCHED_FILL_EN
  regbank_state_e r_state;
  regbank_state_e w_state_nxt;
  logic [AW-1:0]  r_cnt;
  logic           r_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == FILL);
      r_cnt   <= (r_state == FILL) ? r_cnt + AW'(1) : '0;
    end
  end

  // A fill pulse pre-empts arbitration; fill pulses are ignored once filling.
  always_comb begin
    w_state_nxt = r_state;
    w_arb_en    = 1'b0;
    w_fill_we   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_fill) w_state_nxt = FILL;
        else        w_arb_en    = 1'b1;
      end
      FILL: begin
        w_fill_we = 1'b1;
        if (r_cnt == AW'(DEPTH - 1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy = r_busy;
`else
  logic w_unused_fill;

  assign w_arb_en      = 1'b1;
  assign w_fill_we     = 1'b0;
  assign o_busy        = 1'b0;
  assign w_unused_fill = ^{i_fill, i_fill_val};
`endif

  // Single write port: granted requester, or the fill sequencer when active.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (w_gnt[k]) begin
        w_we    = 1'b1;
        w_waddr = i_addr[k];
        w_wdata = i_wdata[k];
      end
    end
`ifdef REGBANK_WR_SCHED_FILL_EN
    if (w_fill_we) begin
      w_we    = 1'b1;
      w_waddr = r_cnt;
      w_wdata = i_fill_val;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_q[i] <= '0;
    end else if (w_we) begin
      r_q[w_waddr] <= w_wdata;
    end
  end

  assign o_q = r_q;

endmodule

// File: tb/tb_regbank_wr_sched.sv
// Randomized self-checking bench for regbank_wr_sched against a queue-free array model;
// fill scenarios are exercised when REGBANK_WR_SCHED_FILL_EN is defined.
module tb_regbank_wr_sched;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          req   [N];
  logic [AW-1:0] addr  [N];
  logic          wdata [N];
  logic          gnt   [N];
  logic          fill;
  logic          fill_val;
  logic          busy;
  logic          q     [D];

  int n_tests;
  int n_fail;

  // Behavioural model: bank contents and round-robin priority pointer.
  logic m_q [D];
  int   m_ptr;

  regbank_wr_sched #(.N_REQ(N), .DEPTH(D), .WIDTH(1)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_gnt      (gnt),
    .i_fill     (fill),
    .i_fill_val (fill_val),
    .o_busy     (busy),
    .o_q        (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_winner();
    for (int o = 0; o < N; o++) begin
      int k;
      k = (m_ptr + o) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < N; k++) begin
      req[k] = 1'b0; addr[k] = '0; wdata[k] = 1'b0;
    end
    fill = 1'b0; fill_val = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < D; i++) m_q[i] = 1'b0;
    m_ptr = 0;
  endtask

  task automatic model_commit(input int w);
    if (w >= 0) begin
      m_q[addr[w]] = wdata[w];
      m_ptr = (w + 1) % N;
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < D; i++) begin
      n_tests++;
      if (q[i] !== 1'b0) begin n_fail++; $display("FAIL reset_q[%0d]: got %b want 0", i, q[i]); end
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (gnt[k] !== 1'b0) begin n_fail++; $display("FAIL reset_gnt[%0d]: got %b want 0", k, gnt[k]); end
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    req[2] = 1'b1; addr[2] = 3'd5; wdata[2] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (gnt[k] !== (k == 2)) begin n_fail++; $display("FAIL single_gnt[%0d]: got %b want %b", k, gnt[k], k == 2); end
    end
    model_commit(2);
    @(posedge clk); #1;
    req[2] = 1'b0;
    for (int i = 0; i < D; i++) begin
      n_tests++;
      if (q[i] !== ((i == 5) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL single_q[%0d]: got %b want %b", i, q[i], i == 5); end
    end
  endtask

  task automatic test_rotation();
    int exp_seq [5];
    exp_seq = '{0, 1, 2, 3, 0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < N; k++) begin
        req[k] = 1'b1; addr[k] = AW'($urandom_range(0, D - 1)); wdata[k] = 1'($urandom);
      end
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        n_tests++;
        if (gnt[k] !== (k == exp_seq[c])) begin
          n_fail++; $display("FAIL rotation c%0d gnt[%0d]: got %b want %b", c, k, gnt[k], k == exp_seq[c]);
        end
      end
      model_commit(exp_seq[c]);
      @(posedge clk); #1;
      for (int i = 0; i < D; i++) begin
        n_tests++;
        if (q[i] !== m_q[i]) begin n_fail++; $display("FAIL rotation c%0d q[%0d]: got %b want %b", c, i, q[i], m_q[i]); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_skip();
    int exp_seq [2];
    exp_seq = '{3, 0};
    do_reset();
    req[1] = 1'b1; addr[1] = 3'd2; wdata[1] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (gnt[1] !== 1'b1) begin n_fail++; $display("FAIL skip_setup gnt[1]: got %b want 1", gnt[1]); end
    model_commit(1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    req[0] = 1'b1; addr[0] = 3'd4; wdata[0] = 1'b1;
    req[3] = 1'b1; addr[3] = 3'd7; wdata[3] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        n_tests++;
        if (gnt[k] !== (k == exp_seq[c])) begin
          n_fail++; $display("FAIL skip c%0d gnt[%0d]: got %b want %b", c, k, gnt[k], k == exp_seq[c]);
        end
      end
      model_commit(exp_seq[c]);
      @(posedge clk); #1;
      req[exp_seq[c]] = 1'b0;
    end
    for (int i = 0; i < D; i++) begin
      n_tests++;
      if (q[i] !== m_q[i]) begin n_fail++; $display("FAIL skip q[%0d]: got %b want %b", i, q[i], m_q[i]); end
    end
  endtask

  task automatic test_random();
    int w;
    for (int c = 0; c < 300; c++) begin
      // Waiting requesters keep req high but may change addr/data.
      for (int k = 0; k < N; k++) begin
        if (!req[k]) req[k] = ($urandom_range(0, 99) < 45);
        addr[k]  = AW'($urandom_range(0, D - 1));
        wdata[k] = 1'($urandom);
      end
      w = model_winner();
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        n_tests++;
        if (gnt[k] !== (k == w)) begin
          n_fail++; $display("FAIL random c%0d gnt[%0d]: got %b want %b", c, k, gnt[k], k == w);
        end
      end
      model_commit(w);
      @(posedge clk); #1;
      if (w >= 0) req[w] = 1'b0;
      for (int i = 0; i < D; i++) begin
        n_tests++;
        if (q[i] !== m_q[i]) begin n_fail++; $display("FAIL random c%0d q[%0d]: got %b want %b", c, i, q[i], m_q[i]); end
      end
    end
    clear_inputs();
  endtask

`ifdef REGBANK_WR_SCHED_FILL_EN
  task automatic test_fill();
    do_reset();
    req[0] = 1'b1; addr[0] = 3'd3; wdata[0] = 1'b0;
    fill = 1'b1; fill_val = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (gnt[k] !== 1'b0) begin n_fail++; $display("FAIL fill_pulse gnt[%0d]: got %b want 0", k, gnt[k]); end
    end
    @(posedge clk); #1;
    fill = 1'b0;
    for (int j = 0; j < D; j++) begin
      fill_val = (j == 2) ? 1'b0 : 1'b1;
      fill     = (j == 4);
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy j%0d: got %b want 1", j, busy); end
      for (int k = 0; k < N; k++) begin
        n_tests++;
        if (gnt[k] !== 1'b0) begin n_fail++; $display("FAIL fill_gnt j%0d [%0d]: got %b want 0", j, k, gnt[k]); end
      end
      m_q[j] = fill_val;
      @(posedge clk); #1;
      for (int i = 0; i < D; i++) begin
        n_tests++;
        if (q[i] !== m_q[i]) begin n_fail++; $display("FAIL fill j%0d q[%0d]: got %b want %b", j, i, q[i], m_q[i]); end
      end
    end
    fill = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_end busy: got %b want 0", busy); end
    n_tests++;
    if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL fill_end gnt[0]: got %b want 1", gnt[0]); end
    model_commit(0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    n_tests++;
    if (q[3] !== m_q[3]) begin n_fail++; $display("FAIL fill_end q[3]: got %b want %b", q[3], m_q[3]); end
  endtask

  task automatic test_fill_reset();
    do_reset();
    fill = 1'b1; fill_val = 1'b1;
    @(posedge clk); #1;
    fill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (q[2] !== 1'b1) begin n_fail++; $display("FAIL fill_rst pre q[2]: got %b want 1", q[2]); end
    rst = 1'b1;
    req[2] = 1'b1; addr[2] = 3'd6; wdata[2] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < D; i++) m_q[i] = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < D; i++) begin
      n_tests++;
      if (q[i] !== 1'b0) begin n_fail++; $display("FAIL fill_rst q[%0d]: got %b want 0", i, q[i]); end
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_rst busy: got %b want 0", busy); end
    n_tests++;
    if (gnt[2] !== 1'b1) begin n_fail++; $display("FAIL fill_rst gnt[2]: got %b want 1", gnt[2]); end
    model_commit(2);
    @(posedge clk); #1;
    req[2] = 1'b0;
    n_tests++;
    if (q[6] !== 1'b1) begin n_fail++; $display("FAIL fill_rst q[6]: got %b want 1", q[6]); end
  endtask
`else
  task automatic test_fill_ignored();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      fill = 1'b1; fill_val = 1'b1;
      req[0] = 1'b1; addr[0] = AW'(c); wdata[0] = 1'b1;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL nofill c%0d busy: got %b want 0", c, busy); end
      n_tests++;
      if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL nofill c%0d gnt[0]: got %b want 1", c, gnt[0]); end
      model_commit(0);
      @(posedge clk); #1;
    end
    clear_inputs();
    for (int i = 0; i < D; i++) begin
      n_tests++;
      if (q[i] !== m_q[i]) begin n_fail++; $display("FAIL nofill q[%0d]: got %b want %b", i, q[i], m_q[i]); end
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_rotation();
    test_skip();
    test_random();
`ifdef REGBANK_WR_SCHED_FILL_EN
    test_fill();
    test_fill_reset();
`else
    test_fill_ignored();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1, "timeout");
  end

endmodule
